seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Parametrised multi-digit hexadecimal 7-segment display controller, successor to the single-digit combinational decoder.
- Accepts an NDIG-digit hex value plus per-digit decimal points over a valid/ready handshake and double-buffers it so updates never tear mid-frame.
- Drives a static parallel segment bus (one 7-bit field per digit) and a time-multiplexed scan bus (shared segments plus active-low digit selects).
- Sits between CPU-side MMIO/debug logic and board LEDs.

Parameters:
- NDIG, 8, number of digits (1..16).
- SCAN_DIV, 1000, clk cycles per scan tick (>=1); one tick advances one digit.
- DIV_W, $clog2(SCAN_DIV+1), prescaler counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  new display value offered
- in_ready  out  1  value accepted when in_valid && in_ready
- in_data  in  NDIG*4  nibble i = digit i, digit 0 rightmost
- in_dp  in  NDIG  decimal point per digit, 1 = lit
- lzs_i  in  1  leading-zero suppression enable, sampled at commit
- hex_o  out  NDIG*7  static segments, field i = digit i, active-low, bit0=a..bit6=g
- dp_o  out  NDIG  static decimal points, active-low
- seg_o  out  7  scanned segments of the selected digit, active-low
- sdp_o  out  1  scanned decimal point, active-low
- dig_sel_o  out  NDIG  one-cold digit select, active-low

Behaviour:
- Encoding, active-low bits 6..0: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110. Blank=1111111.
- Reset: hex_o all 1s, dp_o all 1s, seg_o=7'h7F, sdp_o=1, dig_sel_o all 1s, in_ready=1, prescaler=0, idx=0, pending and display buffers invalid. Reset mid-frame discards pending data and blanks the display on the next edge.
- Prescaler: increments each cycle and wraps at SCAN_DIV-1. tick=1 on the wrap cycle. SCAN_DIV=1 gives tick every cycle.
- Scan index idx advances on tick and wraps NDIG-1 -> 0. A frame boundary is a tick with idx==NDIG-1.
- Handshake: an accept writes the pending buffer and sets pend_vld. in_ready = !pend_vld || commit. Accept and commit in the same cycle: the old pending value commits and the new value becomes pending.
- Commit happens on a frame boundary with pend_vld=1: pending -> display buffer, disp_vld=1, lzs latched, pend_vld cleared unless refilled in the same cycle.
- LZS: when the latched lzs=1, digits NDIG-1 down to 1 are blanked while they and all higher digits are 0. Digit 0 is never blanked. DP is unaffected by blanking.
- hex_o/dp_o are registered and update the cycle after commit. They show blank while disp_vld=0.
- Scan outputs are registered. The cycle after a tick moving to idx=k: dig_sel_o bit k=0 (others 1), seg_o/sdp_o = digit k. While disp_vld=0, dig_sel_o stays all 1s.
- NDIG=1: every tick is a frame boundary and dig_sel_o bit 0 is held low once disp_vld=1.

Optional Feature:
- SEG7_BLINK_EN defined: extra ports blink_mask_i[NDIG] and blink_div_i[7:0].
  - A blink phase toggles every blink_div_i+1 frames.
  - While the phase is 1, masked digits are blanked (segments and DP) on both buses.
  - Phase resets to 0. blink_div_i=0 toggles every frame.
- Undefined: no blink ports, no phase counter, no blanking beyond LZS.

Decomposition:
- Package seg7_pkg: segment encoding constants SEG_BLANK and SEG_HEX[16], the hex2seg function, and the nibble/segment width localparams.
- One natural sub-module, hex7seg_dec: combinational nibble + blank -> 7-bit active-low segments. It is instantiated NDIG times for the static bus and once for the scan path.

Test Plan:
- Reset, no input, 5 frames -> hex_o all 1s, dig_sel_o all 1s, in_ready=1.
- NDIG=4, SCAN_DIV=1, send 16'h12AF, dp=4'b0010 -> after the next frame boundary plus 1 cycle, hex_o = {1111001,0100100,0001000,0001110}, dp_o=4'b1101. Scan shows digit 0 = 0001110 with dig_sel_o=4'b1110.
- Two back-to-back sends 0x1111 then 0x2222 with a third held valid -> in_ready drops after the second. The third is accepted on the commit cycle. Display goes 1111 -> 2222 at consecutive frame boundaries, never mixed digits.
- lzs_i=1, value 0x0040 -> digits 3,2 blank, digit 1 = 0011001, digit 0 = 1000000. Value 0x0000 -> only digit 0 lit.
- SCAN_DIV=3: measure the dig_sel_o period -> each digit is active for exactly 3 cycles and the order is 0,1,2,3,0.
- SEG7_BLINK_EN, mask=4'b0001, blink_div_i=1 -> digit 0 alternates lit/blank every 2 frames. Other digits are always lit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared segment encoding for the 7-segment display blocks.
// Segments are active-low, bit0 = a .. bit6 = g.
package seg7_pkg;

    localparam int NIB_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [0:15][SEG_W-1:0] SEG_HEX = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [SEG_W-1:0] hex2seg(input logic [NIB_W-1:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble to active-low 7-segment decoder with blank override.
module hex7seg_dec
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : hex2seg(nib_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multi-digit hex 7-segment controller: double-buffered value, static and scanned buses.
// Define SEG7_BLINK_EN to add per-digit blinking (blink_mask_i, blink_div_i).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG     = 8,
    parameter int SCAN_DIV = 1000,
    parameter int DIV_W    = $clog2(SCAN_DIV + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NDIG*NIB_W-1:0] in_data,
    input  logic [NDIG-1:0]       in_dp,
    input  logic                  lzs_i,
`ifdef SEG7_BLINK_EN
    input  logic [NDIG-1:0]       blink_mask_i,
    input  logic [7:0]            blink_div_i,
`endif
    output logic [NDIG*SEG_W-1:0] hex_o,
    output logic [NDIG-1:0]       dp_o,
    output logic [SEG_W-1:0]      seg_o,
    output logic                  sdp_o,
    output logic [NDIG-1:0]       dig_sel_o
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick, frame_end, commit, accept;

    logic                        pend_vld_q, pend_vld_d;
    logic [NDIG-1:0][NIB_W-1:0]  pend_nib_q, pend_nib_d;
    logic [NDIG-1:0]             pend_dp_q, pend_dp_d;
    logic                        disp_vld_q, disp_vld_d;
    logic [NDIG-1:0][NIB_W-1:0]  disp_nib_q, disp_nib_d;
    logic [NDIG-1:0]             disp_dp_q, disp_dp_d;
    logic                        disp_lzs_q, disp_lzs_d;

    logic [NDIG-1:0]             lzs_blank, blink_blank, seg_blank, dp_blank;
    logic [NDIG-1:0][SEG_W-1:0]  hex_q, hex_d;
    logic [NDIG-1:0]             dp_q, dp_d;
    logic [SEG_W-1:0]            seg_q, seg_d;
    logic                        sdp_q;
    logic [NDIG-1:0]             sel_q, sel_d;
    logic                        lead;

    assign tick      = (div_q == DIV_LAST);
    assign frame_end = tick && (idx_q == IDX_LAST);
    assign commit    = frame_end && pend_vld_q;
    assign in_ready  = !pend_vld_q || commit;
    assign accept    = in_valid && in_ready;

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Commit is applied before accept so a same-cycle refill keeps pend_vld set.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_nib_d = pend_nib_q;
        pend_dp_d  = pend_dp_q;
        disp_vld_d = disp_vld_q;
        disp_nib_d = disp_nib_q;
        disp_dp_d  = disp_dp_q;
        disp_lzs_d = disp_lzs_q;
        if (commit) begin
            disp_vld_d = 1'b1;
            disp_nib_d = pend_nib_q;
            disp_dp_d  = pend_dp_q;
            disp_lzs_d = lzs_i;
            pend_vld_d = 1'b0;
        end
        if (accept) begin
            pend_vld_d = 1'b1;
            pend_nib_d = in_data;
            pend_dp_d  = in_dp;
        end
    end

    // Leading-zero run scanned from the top digit; digit 0 always stays lit.
    always_comb begin
        lead      = disp_lzs_d;
        lzs_blank = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            lead         = lead && (disp_nib_d[i] == '0);
            lzs_blank[i] = lead && (i != 0);
        end
    end

`ifdef SEG7_BLINK_EN
    logic       phase_q, phase_d;
    logic [7:0] bcnt_q, bcnt_d;

    always_comb begin
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        if (frame_end) begin
            if (bcnt_q >= blink_div_i) begin
                bcnt_d  = '0;
                phase_d = !phase_q;
            end else begin
                bcnt_d = bcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign blink_blank = blink_mask_i & {NDIG{phase_d}};
`else
    assign blink_blank = '0;
`endif

    assign seg_blank = {NDIG{!disp_vld_d}} | lzs_blank | blink_blank;
    assign dp_blank  = {NDIG{!disp_vld_d}} | blink_blank;
    assign dp_d      = ~disp_dp_d | dp_blank;
    assign sel_d     = disp_vld_d ? ~(NDIG'(1) << idx_d) : '1;

    // Outputs are decoded from next-state so they register on the commit/tick edge.
    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        hex7seg_dec u_dec (
            .nib_i  (disp_nib_d[g]),
            .blank_i(seg_blank[g]),
            .seg_o  (hex_d[g])
        );
    end

    hex7seg_dec u_scan_dec (
        .nib_i  (disp_nib_d[idx_d]),
        .blank_i(seg_blank[idx_d]),
        .seg_o  (seg_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q      <= '0;
            idx_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_nib_q <= '0;
            pend_dp_q  <= '0;
            disp_vld_q <= 1'b0;
            disp_nib_q <= '0;
            disp_dp_q  <= '0;
            disp_lzs_q <= 1'b0;
            hex_q      <= '1;
            dp_q       <= '1;
            seg_q      <= SEG_BLANK;
            sdp_q      <= 1'b1;
            sel_q      <= '1;
        end else begin
            div_q      <= div_d;
            idx_q      <= idx_d;
            pend_vld_q <= pend_vld_d;
            pend_nib_q <= pend_nib_d;
            pend_dp_q  <= pend_dp_d;
            disp_vld_q <= disp_vld_d;
            disp_nib_q <= disp_nib_d;
            disp_dp_q  <= disp_dp_d;
            disp_lzs_q <= disp_lzs_d;
            hex_q      <= hex_d;
            dp_q       <= dp_d;
            seg_q      <= seg_d;
            sdp_q      <= dp_d[idx_d];
            sel_q      <= sel_d;
        end
    end

    assign hex_o     = hex_q;
    assign dp_o      = dp_q;
    assign seg_o     = seg_q;
    assign sdp_o     = sdp_q;
    assign dig_sel_o = sel_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: NDIG=4 at SCAN_DIV=1 (main) and SCAN_DIV=3 (scan timing).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_dp = '0;
    logic        lzs = 1'b0;
    logic        rdy1, rdy3;
    logic [27:0] hex1, hex3;
    logic [3:0]  dp1, dp3, sel1, sel3;
    logic [6:0]  seg1, seg3;
    logic        sdp1, sdp3;
`ifdef SEG7_BLINK_EN
    logic [3:0]  bmask = '0;
    logic [7:0]  bdiv = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NDIG(4), .SCAN_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_dp(in_dp), .lzs_i(lzs),
`ifdef SEG7_BLINK_EN
        .blink_mask_i(bmask), .blink_div_i(bdiv),
`endif
        .hex_o(hex1), .dp_o(dp1), .seg_o(seg1), .sdp_o(sdp1), .dig_sel_o(sel1)
    );

    seg7_scan_ctrl #(.NDIG(4), .SCAN_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .in_data(in_data), .in_dp(in_dp), .lzs_i(lzs),
`ifdef SEG7_BLINK_EN
        .blink_mask_i(bmask), .blink_div_i(bdiv),
`endif
        .hex_o(hex3), .dp_o(dp3), .seg_o(seg3), .sdp_o(sdp3), .dig_sel_o(sel3)
    );

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Offer one value on dut and drop valid right after it is taken.
    task automatic send(input logic [15:0] d, input logic [3:0] dp);
        int n = 0;
        in_data = d; in_dp = dp; in_valid = 1'b1;
        while (!rdy1 && n < 20) begin cyc(1); n++; end
        checks++;
        if (!rdy1) begin errors++; $display("FAIL send_ready_timeout got=%b want=1", rdy1); end
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(3);
        checks++; if (hex1 !== '1) begin errors++; $display("FAIL rst_hex got=%h want=fffffff", hex1); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", rdy1); end
        rst_n = 1'b1;
        cyc(20);
        checks++; if (hex1 !== '1) begin errors++; $display("FAIL idle_hex got=%h want=fffffff", hex1); end
        checks++; if (dp1 !== 4'hF) begin errors++; $display("FAIL idle_dp got=%b want=1111", dp1); end
        checks++; if (sel1 !== 4'hF) begin errors++; $display("FAIL idle_sel got=%b want=1111", sel1); end
        checks++; if (seg1 !== 7'h7F || sdp1 !== 1'b1) begin errors++; $display("FAIL idle_seg got=%h/%b want=7f/1", seg1, sdp1); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b want=1", rdy1); end
        checks++; if (sel3 !== 4'hF) begin errors++; $display("FAIL idle_sel3 got=%b want=1111", sel3); end
    endtask

    task automatic test_basic;
        int n = 0;
        send(16'h12AF, 4'b0010);
        while (!rdy1 && n < 10) begin cyc(1); n++; end
        checks++; if (!rdy1) begin errors++; $display("FAIL basic_commit_timeout got=%b want=1", rdy1); end
        checks++; if (hex1 !== '1) begin errors++; $display("FAIL basic_precommit got=%h want=fffffff", hex1); end
        cyc(1);
        checks++; if (hex1 !== {7'h79, 7'h24, 7'h08, 7'h0E}) begin errors++; $display("FAIL basic_hex got=%h want=%h", hex1, {7'h79, 7'h24, 7'h08, 7'h0E}); end
        checks++; if (dp1 !== 4'b1101) begin errors++; $display("FAIL basic_dp got=%b want=1101", dp1); end
        checks++; if (sel1 !== 4'b1110 || seg1 !== 7'h0E || sdp1 !== 1'b1) begin errors++; $display("FAIL basic_scan0 got=%b/%h/%b want=1110/0e/1", sel1, seg1, sdp1); end
        cyc(1);
        checks++; if (sel1 !== 4'b1101 || seg1 !== 7'h08 || sdp1 !== 1'b0) begin errors++; $display("FAIL basic_scan1 got=%b/%h/%b want=1101/08/0", sel1, seg1, sdp1); end
        cyc(1);
        checks++; if (sel1 !== 4'b1011 || seg1 !== 7'h24) begin errors++; $display("FAIL basic_scan2 got=%b/%h want=1011/24", sel1, seg1); end
        cyc(1);
        checks++; if (sel1 !== 4'b0111 || seg1 !== 7'h79) begin errors++; $display("FAIL basic_scan3 got=%b/%h want=0111/79", sel1, seg1); end
    endtask

    task automatic test_back_to_back;
        int n;
        in_data = 16'h1111; in_dp = '0; in_valid = 1'b1;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got=%b want=1", rdy1); end
        cyc(1);
        in_data = 16'h2222;
        n = 0;
        while (!rdy1 && n < 10) begin cyc(1); n++; end
        checks++; if (hex1 !== {7'h79, 7'h24, 7'h08, 7'h0E}) begin errors++; $display("FAIL b2b_old_hex got=%h", hex1); end
        cyc(1);
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got=%b want=0", rdy1); end
        checks++; if (hex1 !== {4{7'h79}}) begin errors++; $display("FAIL b2b_hex1111 got=%h want=%h", hex1, {4{7'h79}}); end
        in_data = 16'h3333;
        n = 0;
        while (!rdy1 && n < 10) begin
            checks++; if (hex1 !== {4{7'h79}}) begin errors++; $display("FAIL b2b_hold1111 got=%h", hex1); end
            cyc(1); n++;
        end
        checks++; if (!rdy1) begin errors++; $display("FAIL b2b_third_timeout got=%b want=1", rdy1); end
        cyc(1);
        in_valid = 1'b0;
        checks++; if (hex1 !== {4{7'h24}}) begin errors++; $display("FAIL b2b_hex2222 got=%h want=%h", hex1, {4{7'h24}}); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL b2b_third_pending got=%b want=0", rdy1); end
        n = 0;
        while (!rdy1 && n < 10) begin
            checks++; if (hex1 !== {4{7'h24}}) begin errors++; $display("FAIL b2b_hold2222 got=%h", hex1); end
            cyc(1); n++;
        end
        cyc(1);
        checks++; if (hex1 !== {4{7'h30}}) begin errors++; $display("FAIL b2b_hex3333 got=%h want=%h", hex1, {4{7'h30}}); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got=%b want=1", rdy1); end
    endtask

    task automatic test_lzs;
        int n = 0;
        lzs = 1'b1;
        send(16'h0040, 4'b0000); cyc(6);
        checks++; if (hex1 !== {7'h7F, 7'h7F, 7'h19, 7'h40}) begin errors++; $display("FAIL lzs_0040 got=%h want=%h", hex1, {7'h7F, 7'h7F, 7'h19, 7'h40}); end
        while (sel1 !== 4'b1011 && n < 8) begin cyc(1); n++; end
        checks++; if (sel1 !== 4'b1011 || seg1 !== 7'h7F) begin errors++; $display("FAIL lzs_scan2 got=%b/%h want=1011/7f", sel1, seg1); end
        send(16'h0000, 4'b1000); cyc(6);
        checks++; if (hex1 !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL lzs_0000 got=%h want=%h", hex1, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
        checks++; if (dp1 !== 4'b0111) begin errors++; $display("FAIL lzs_dp got=%b want=0111", dp1); end
        send(16'h0400, 4'b0000); cyc(6);
        checks++; if (hex1 !== {7'h7F, 7'h19, 7'h40, 7'h40}) begin errors++; $display("FAIL lzs_0400 got=%h want=%h", hex1, {7'h7F, 7'h19, 7'h40, 7'h40}); end
        lzs = 1'b0;
        send(16'h0040, 4'b0000); cyc(6);
        checks++; if (hex1 !== {7'h40, 7'h40, 7'h19, 7'h40}) begin errors++; $display("FAIL nolzs_0040 got=%h want=%h", hex1, {7'h40, 7'h40, 7'h19, 7'h40}); end
    endtask

    task automatic test_scan_div3;
        logic [3:0] seq [4];
        logic [3:0] prev;
        logic       found = 1'b0;
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
        prev = sel3;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (prev == 4'b0111 && sel3 == 4'b1110) found = 1'b1;
            prev = sel3;
        end
        checks++; if (!found) begin errors++; $display("FAIL div3_sync_timeout got=%b want=1110", sel3); end
        for (int c = 1; c < 15; c++) begin
            cyc(1);
            checks++;
            if (sel3 !== seq[(c / 3) % 4]) begin errors++; $display("FAIL div3_sel c=%0d got=%b want=%b", c, sel3, seq[(c / 3) % 4]); end
        end
    endtask

    task automatic test_reset_mid;
        send(16'h5555, 4'b1111);
        rst_n = 1'b0;
        cyc(1);
        checks++; if (hex1 !== '1 || sel1 !== 4'hF || dp1 !== 4'hF) begin errors++; $display("FAIL midrst_blank got=%h/%b/%b", hex1, sel1, dp1); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", rdy1); end
        rst_n = 1'b1;
        cyc(12);
        checks++; if (hex1 !== '1 || sel1 !== 4'hF) begin errors++; $display("FAIL midrst_discard got=%h/%b want=fffffff/1111", hex1, sel1); end
    endtask

`ifdef SEG7_BLINK_EN
    task automatic test_blink;
        logic s [10];
        bmask = 4'b0001; bdiv = 8'd1;
        send(16'h1234, 4'b0001); cyc(6);
        for (int k = 0; k < 10; k++) begin
            s[k] = (hex1[6:0] == 7'h7F);
            checks++; if (hex1[27:7] !== {7'h79, 7'h24, 7'h30}) begin errors++; $display("FAIL blink_other k=%0d got=%h", k, hex1[27:7]); end
            checks++;
            if (s[k] ? (dp1[0] !== 1'b1) : (hex1[6:0] !== 7'h19 || dp1[0] !== 1'b0)) begin
                errors++; $display("FAIL blink_dig0 k=%0d got=%h/%b", k, hex1[6:0], dp1[0]);
            end
            cyc(4);
        end
        for (int k = 0; k < 8; k++) begin
            checks++; if (s[k] === s[k+2]) begin errors++; $display("FAIL blink_period k=%0d got=%b want=%b", k, s[k+2], !s[k]); end
        end
        bmask = '0;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_lzs;
        test_scan_div3;
        test_reset_mid;
`ifdef SEG7_BLINK_EN
        test_blink;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
